// File: rtl/jc2_seq.sv
// rtl/jc2_seq.sv - run-length sequencer and round-robin arbiter for a bidirectional Johnson counter
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   l_req, l_steps      left client request level and run length (sampled on grant)
//   l_ack               one-cycle pulse when the left request is granted
//   r_req, r_steps      right client request level and run length (sampled on grant)
//   r_ack               one-cycle pulse when the right request is granted
//   goLeft, goRight     counter shift enables, high for exactly `steps` cycles
//   stop                counter hold, high whenever neither go output is high
//   busy                high while a run or its trailing stop gap is in progress
//   done                one-cycle pulse at the end of every granted run
//   last_dir            direction of the most recent grant (1 = left)
module jc2_seq #(
  parameter int STEP_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l_req,
  input  logic [STEP_W-1:0] l_steps,
  output logic              l_ack,
  input  logic              r_req,
  input  logic [STEP_W-1:0] r_steps,
  output logic              r_ack,
  output logic              goLeft,
  output logic              goRight,
  output logic              stop,
  output logic              busy,
  output logic              done,
  output logic              last_dir
);

  // Gap counter holds up to GAP_CYCLES (zero-length runs spend one extra cycle).
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_FULL = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              done_pend_q, done_pend_d;
  logic              go_left_q, go_left_d;
  logic              go_right_q, go_right_d;
  logic              stop_q, stop_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              l_ack_q, l_ack_d;
  logic              r_ack_q, r_ack_d;
  logic              last_dir_q, last_dir_d;

  logic              grant_l, grant_r;
  logic [STEP_W-1:0] sel_steps;

  // On a tie the direction opposite to the previous grant wins.
  assign grant_l   = l_req & (~r_req | ~last_dir_q);
  assign grant_r   = r_req & (~l_req | last_dir_q);
  assign sel_steps = grant_l ? l_steps : r_steps;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    done_pend_d = done_pend_q;
    go_left_d   = go_left_q;
    go_right_d  = go_right_q;
    stop_d      = stop_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    l_ack_d     = 1'b0;
    r_ack_d     = 1'b0;
    last_dir_d  = last_dir_q;

    case (state_q)
      S_IDLE: begin
        go_left_d  = 1'b0;
        go_right_d = 1'b0;
        stop_d     = 1'b1;
        busy_d     = 1'b0;
        if (grant_l || grant_r) begin
          l_ack_d    = grant_l;
          r_ack_d    = grant_r;
          last_dir_d = grant_l;
          cnt_d      = sel_steps;
          busy_d     = 1'b1;
          if (sel_steps != '0) begin
            state_d    = S_RUN;
            go_left_d  = grant_l;
            go_right_d = grant_r;
            stop_d     = 1'b0;
          end else begin
            // The ack cycle counts as an extra gap cycle so done lands after it.
            state_d     = S_GAP;
            gcnt_d      = GAP_FULL;
            done_pend_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == STEP_W'(1)) begin
          state_d    = S_GAP;
          go_left_d  = 1'b0;
          go_right_d = 1'b0;
          stop_d     = 1'b1;
          done_d     = 1'b1;
          gcnt_d     = GAP_LAST;
        end
      end

      S_GAP: begin
        done_d      = done_pend_q;
        done_pend_d = 1'b0;
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        go_left_d  = 1'b0;
        go_right_d = 1'b0;
        stop_d     = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      done_pend_q <= 1'b0;
      go_left_q   <= 1'b0;
      go_right_q  <= 1'b0;
      stop_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      l_ack_q     <= 1'b0;
      r_ack_q     <= 1'b0;
      last_dir_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      done_pend_q <= done_pend_d;
      go_left_q   <= go_left_d;
      go_right_q  <= go_right_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      l_ack_q     <= l_ack_d;
      r_ack_q     <= r_ack_d;
      last_dir_q  <= last_dir_d;
    end
  end

  assign goLeft   = go_left_q;
  assign goRight  = go_right_q;
  assign stop     = stop_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign l_ack    = l_ack_q;
  assign r_ack    = r_ack_q;
  assign last_dir = last_dir_q;

endmodule

// File: tb/tb_jc2_seq.sv
// tb/tb_jc2_seq.sv - self-checking bench for jc2_seq against a run-timeline reference model
module tb_jc2_seq;

  localparam int STEP_W = 4;
  localparam int GAP    = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              l_req = 1'b0;
  logic [STEP_W-1:0] l_steps = '0;
  logic              r_req = 1'b0;
  logic [STEP_W-1:0] r_steps = '0;
  logic              l_ack, r_ack, goLeft, goRight, stop, busy, done, last_dir;

  jc2_seq #(.STEP_W(STEP_W), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .l_req    (l_req),
    .l_steps  (l_steps),
    .l_ack    (l_ack),
    .r_req    (r_req),
    .r_steps  (r_steps),
    .r_ack    (r_ack),
    .goLeft   (goLeft),
    .goRight  (goRight),
    .stop     (stop),
    .busy     (busy),
    .done     (done),
    .last_dir (last_dir)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a granted run is a timeline anchored at its grant edge.
  int edge_k = 0;
  bit m_active = 0;
  int m_g = 0;
  int m_n = 0;
  int m_blen = 0;
  bit m_dir = 0;
  bit m_last = 0;

  bit e_l_ack, e_r_ack, e_go_l, e_go_r, e_stop, e_busy, e_done, e_last;

  bit l_hold = 0;
  bit r_hold = 0;
  bit rand_mode = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d edge=%0d", tag, act, exp, edge_k);
    end
  endtask

  task automatic tick();
    int  d;
    bit  gl, gr, go;
    @(posedge clk);
    edge_k++;
    if (reset) begin
      m_active = 0;
      m_last   = 0;
    end else begin
      if (m_active && (edge_k - m_g) > m_blen) m_active = 0;
      if (!m_active) begin
        gl = l_req && (!r_req || !m_last);
        gr = r_req && (!l_req || m_last);
        if (gl || gr) begin
          m_active = 1;
          m_g      = edge_k;
          m_dir    = gl;
          m_n      = gl ? int'(l_steps) : int'(r_steps);
          m_blen   = (m_n > 0) ? m_n + GAP : 1 + GAP;
          m_last   = gl;
        end
      end
    end
    d       = edge_k - m_g;
    go      = m_active && (m_n > 0) && (d < m_n);
    e_l_ack = m_active && (d == 0) && m_dir;
    e_r_ack = m_active && (d == 0) && !m_dir;
    e_go_l  = go && m_dir;
    e_go_r  = go && !m_dir;
    e_stop  = !go;
    e_busy  = m_active && (d < m_blen);
    e_done  = m_active && ((m_n > 0) ? (d == m_n) : (d == 1));
    e_last  = m_last;
    #1;
    check("l_ack",    l_ack,    e_l_ack);
    check("r_ack",    r_ack,    e_r_ack);
    check("goLeft",   goLeft,   e_go_l);
    check("goRight",  goRight,  e_go_r);
    check("stop",     stop,     e_stop);
    check("busy",     busy,     e_busy);
    check("done",     done,     e_done);
    check("last_dir", last_dir, e_last);
    check("go_excl",  goLeft & goRight, 0);
    // Clients drop their request after an ack unless told to hold it.
    if (e_l_ack && !l_hold) l_req = 0;
    if (e_r_ack && !r_hold) r_req = 0;
    if (rand_mode) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!l_req) begin
        if ($urandom_range(0, 3) == 0) begin
          l_req = 1;
          l_steps = STEP_W'($urandom_range(0, 15));
        end
      end else if (!e_l_ack && $urandom_range(0, 19) == 0) begin
        l_req = 0;
      end
      if (!r_req) begin
        if ($urandom_range(0, 3) == 0) begin
          r_req = 1;
          r_steps = STEP_W'($urandom_range(0, 15));
        end
      end else if (!e_r_ack && $urandom_range(0, 19) == 0) begin
        r_req = 0;
      end
      if ($urandom_range(0, 9) == 0) l_steps = STEP_W'($urandom_range(0, 15));
      l_hold = ($urandom_range(0, 3) == 0);
      r_hold = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    reset = 1;
    ticks(3);
    reset = 0;
    ticks(2);

    // Single left run of 3 steps
    l_req = 1; l_steps = 4'd3;
    ticks(8);

    // Tie with both requests held: grants alternate starting from left
    reset = 1; tick(); reset = 0;
    l_req = 1; r_req = 1; l_steps = 4'd2; r_steps = 4'd2;
    l_hold = 1; r_hold = 1;
    ticks(17);
    l_hold = 0; r_hold = 0;
    l_req = 0; r_req = 0;
    ticks(5);

    // Zero-length right run
    r_req = 1; r_steps = 4'd0;
    ticks(5);

    // Maximum-length left run
    l_req = 1; l_steps = 4'd15;
    ticks(20);

    // Reset during the 4th RUN cycle of a 10-step right run, then a tie
    r_req = 1; r_steps = 4'd10;
    ticks(4);
    reset = 1; tick(); reset = 0;
    ticks(2);
    l_req = 1; r_req = 1; l_steps = 4'd1; r_steps = 4'd1;
    ticks(8);

    // Withdraw during a left run, then a held request served after the gap
    l_req = 1; l_steps = 4'd4;
    ticks(2);
    r_req = 1; r_steps = 4'd2;
    ticks(2);
    r_req = 0;
    ticks(6);
    l_req = 1; l_steps = 4'd3;
    ticks(2);
    r_req = 1; r_steps = 4'd2;
    ticks(12);

    // Reset and request in the same cycle: reset wins
    reset = 1; l_req = 1; l_steps = 4'd2;
    tick();
    reset = 0; l_req = 0;
    ticks(3);

    // Randomized traffic
    rand_mode = 1;
    ticks(4000);
    rand_mode = 0;
    reset = 0; l_req = 0; r_req = 0;
    ticks(25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
